// File: rtl/multicycle_control_pkg.sv
// Shared multicycle CPU definitions: state codes, opcodes,
// ALU op encodings and the control-word bundle.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) ||
           (op == OP_ANDI);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences
// fetch/decode/execute/memory/write-back one instruction at a time.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegal,
  output logic [3:0] state
);

  state_t cur;
  state_t nxt;
  ctrl_t  c;
  ctrl_t  g;

  // zero is combined with pcWriteCond in the PC load logic
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:   nxt = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_RTYPE):
            nxt = S_REXEC;
          (opcode == OP_LW) || (opcode == OP_SW):
            nxt = S_MEMADDR;
          (opcode == OP_BEQ):
            nxt = S_BRANCH;
          (opcode == OP_J):
            nxt = S_JUMP;
          (opcode == OP_ADDI) || (opcode == OP_ANDI):
            nxt = S_IEXEC;
          default:
            nxt = S_FETCH;
        endcase
      end
      S_MEMADDR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = memReady ? S_FETCH : S_MEMWR;
      S_REXEC:   nxt = S_RWB;
      S_RWB:     nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      S_IEXEC:   nxt = S_IWB;
      S_IWB:     nxt = S_FETCH;
      default:   nxt = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (cur)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = memReady;
        c.pc_write  = memReady;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        c.illegal   = !is_legal(opcode);
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_REXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_JUMP;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (opcode == OP_ANDI) ? ALU_IMM : ALU_ADD;
      end
      S_IWB:     c.reg_write = 1'b1;
      default:   c = '0;
    endcase
  end

  // Reset masks everything, so no fetch strobe is issued under reset
  assign g     = rst ? '0 : c;
  assign state = rst ? 4'd0 : cur;

  assign pcWrite     = g.pc_write;
  assign pcWriteCond = g.pc_write_cond;
  assign iorD        = g.iord;
  assign memRead     = g.mem_read;
  assign memWrite    = g.mem_write;
  assign irWrite     = g.ir_write;
  assign memToReg    = g.mem_to_reg;
  assign regDst      = g.reg_dst;
  assign regWrite    = g.reg_write;
  assign aluSrcA     = g.alu_src_a;
  assign aluSrcB     = g.alu_src_b;
  assign aluOp       = g.alu_op;
  assign pcSource    = g.pc_source;
  assign illegal     = g.illegal;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle CPU. Sequences one instruction at a time through fetch, decode, execute, memory and write-back, driving the datapath mux selects, register/PC/IR write enables and memory strobes. Produces the 2-bit `aluOp` consumed by the ALU function decoder. Holds in memory states until the memory reports ready.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `zero`  in  1  ALU zero flag, combinational
- `memReady`  in  1  memory completed current read/write this cycle
- `pcWrite`  out  1  unconditional PC load
- `pcWriteCond`  out  1  PC load if `zero`
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memRead`  out  1  memory read strobe
- `memWrite`  out  1  memory write strobe
- `irWrite`  out  1  IR load
- `memToReg`  out  1  register write data: 0 = ALUOut, 1 = MDR
- `regDst`  out  1  destination: 0 = rt, 1 = rd
- `regWrite`  out  1  register file write
- `aluSrcA`  out  1  0 = PC, 1 = A
- `aluSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- `aluOp`  out  2  00 add, 01 sub, 10 funct, 11 opcode-immediate
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal`  out  1  one-cycle pulse in DECODE for unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- State register, 4 bits; all outputs are combinational from state, plus `memReady`/`opcode`. Any output not listed for a state is 0.
- FETCH (0): `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=00, `pcSource`=00. `irWrite` and `pcWrite` = `memReady`. On `memReady` go to DECODE, else stay.
- DECODE (1): `aluSrcA`=0, `aluSrcB`=11, `aluOp`=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011/101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000/001100 → I_EXEC
  - other → FETCH with `illegal`=1
- MEM_ADDR (2): `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Next: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ (3): `memRead`=1, `iorD`=1. On `memReady` → MEM_WB, else stay.
- MEM_WB (4): `regWrite`=1, `memToReg`=1, `regDst`=0 → FETCH.
- MEM_WRITE (5): `memWrite`=1, `iorD`=1. On `memReady` → FETCH, else stay.
- R_EXEC (6): `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10 → R_WB.
- R_WB (7): `regWrite`=1, `regDst`=1, `memToReg`=0 → FETCH.
- BRANCH (8): `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01 → FETCH.
- JUMP (9): `pcWrite`=1, `pcSource`=10 → FETCH.
- I_EXEC (10): `aluSrcA`=1, `aluSrcB`=10; `aluOp`=00 for 001000 (ADDI), 11 for 001100 (ANDI) → I_WB.
- I_WB (11): `regWrite`=1, `regDst`=0, `memToReg`=0 → FETCH.
- Codes 12–15 are unreachable; if ever entered, next state is FETCH and all outputs are 0.

## Timing
- `rst` high forces state to FETCH immediately, asynchronously. While `rst`=1 every output is 0 (`state` reads 0). This includes `memRead`, so no fetch is issued under reset.
- First fetch strobe appears in the cycle `rst` deasserts. Reset mid-instruction abandons it; no write strobe persists after `rst` rises.
- `opcode` is sampled in DECODE, MEM_ADDR and I_EXEC. The IR is stable there because `irWrite` fires only in FETCH.
- Memory states hold strobes and address select constant until `memReady`. `memReady` outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Cycle counts with zero-wait memory:
  - R-type, ADDI, ANDI, SW: 4
  - LW: 5
  - BEQ, J: 3
  - illegal: 2
- Each wait cycle adds 1.

## Structure
- State codes and opcode constants (R-type, LW, SW, BEQ, J, ADDI, ANDI) go in the shared CPU define header, alongside the ALU op codes.
- `aluOp` encodings also belong in that header so the ALU function decoder and this FSM agree.
- Single module, no sub-module. The next-state and output decode are two `always @(*)` blocks beside one async-reset state register.

## Test plan
- Reset, then R-type (opcode 000000) with `memReady` tied 1 → states 0,1,6,7,0. `irWrite`=1 in cycle 0, `aluOp`=10 in cycle 2, `regWrite`=`regDst`=1 in cycle 3.
- LW with `memReady` low 2 cycles in MEM_READ → states 0,1,2,3,3,3,4. `memRead`=`iorD`=1 held throughout; `memToReg`=1 in MEM_WB; 7 cycles total.
- BEQ → BRANCH shows `aluOp`=01, `pcWriteCond`=1, `pcSource`=01. ANDI → I_EXEC shows `aluOp`=11. ADDI → I_EXEC shows `aluOp`=00.
- Opcode 111111 → `illegal` pulses one cycle in DECODE, next state FETCH, no `regWrite` or `memWrite` asserted.
- `rst` asserted mid-MEM_WRITE (`memReady`=0) → `memWrite` drops the same cycle, `state`=0. After release, `memRead`=1 in the first cycle.
- J with FETCH wait of 3 cycles → `pcWrite`=0 until `memReady`. JUMP has `pcWrite`=1 and `pcSource`=10.
